// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared constants and decode helpers for the multi-cycle control unit
//
// Purpose: opcode map, ALU command codes, write-data select codes and the
// controller state encoding used by ctrl_multiciclo and ctrl_branch_eval.
// Ports: none (package).

package ctrl_pkg;

  // Opcodes. ADD..CPY are contiguous: they form the register-writing ALU group.
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_AND    = 4'h1;
  localparam logic [3:0] OP_OR     = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [3:0] OP_NEG    = 4'h4;
  localparam logic [3:0] OP_NOT    = 4'h5;
  localparam logic [3:0] OP_CPY    = 4'h6;
  localparam logic [3:0] OP_LRG    = 4'h7;
  localparam logic [3:0] OP_JMP    = 4'h8;
  localparam logic [3:0] OP_BLT    = 4'h9;
  localparam logic [3:0] OP_BGT    = 4'hA;
  localparam logic [3:0] OP_BEQ    = 4'hB;
  localparam logic [3:0] OP_BNE    = 4'hC;
  localparam logic [3:0] OP_INPUT  = 4'hD;
  localparam logic [3:0] OP_OUTPUT = 4'hE;
  localparam logic [3:0] OP_NOP    = 4'hF;

  // ALU commands
  localparam logic [2:0] ALU_TSTR1 = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_SUB   = 3'd4;
  localparam logic [2:0] ALU_NEG   = 3'd5;
  localparam logic [2:0] ALU_NOT   = 3'd6;

  // Register-bank write-data select
  localparam logic [1:0] DT_ALU = 2'd0;
  localparam logic [1:0] DT_IMM = 2'd1;
  localparam logic [1:0] DT_IN  = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_IOWAIT = 3'd4,
    S_UPDATE = 3'd5
  } state_t;

  function automatic logic [2:0] alu_cmd(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SUB:  return ALU_SUB;
      OP_NEG:  return ALU_NEG;
      OP_NOT:  return ALU_NOT;
      default: return ALU_TSTR1;
    endcase
  endfunction

  function automatic logic [1:0] dt_sel(input logic [3:0] op);
    case (op)
      OP_LRG:   return DT_IMM;
      OP_INPUT: return DT_IN;
      default:  return DT_ALU;
    endcase
  endfunction

  // Opcodes whose result is written back during EXEC
  function automatic logic writes_in_exec(input logic [3:0] op);
    return (op <= OP_CPY) || (op == OP_LRG);
  endfunction

  function automatic logic is_io(input logic [3:0] op);
    return (op == OP_INPUT) || (op == OP_OUTPUT);
  endfunction

endpackage

// File: rtl/ctrl_multiciclo_if.sv
// rtl/ctrl_multiciclo_if.sv - datapath/controller bus of the multi-cycle control unit
//
// Purpose: groups opcode, ALU result, handshakes and all control strobes.
// Ports (signals): OP, ResultULA, mem_ready, in_valid, out_ready toward the
// controller; estado, selDtWr, SelRegWr, Wr, CmdULA, LdPC, SelJMP, SelDesv,
// LdOUTPUT, in_ack, io_err from the controller.
// Modports: master = datapath side, slave = controller side.

interface ctrl_multiciclo_if #(
  parameter int DATA_W = 8
);
  logic [3:0]        OP;
  logic [DATA_W-1:0] ResultULA;
  logic              mem_ready;
  logic              in_valid;
  logic              out_ready;
  logic [2:0]        estado;
  logic [1:0]        selDtWr;
  logic              SelRegWr;
  logic              Wr;
  logic [2:0]        CmdULA;
  logic              LdPC;
  logic              SelJMP;
  logic              SelDesv;
  logic              LdOUTPUT;
  logic              in_ack;
  logic              io_err;

  modport master (
    output OP, ResultULA, mem_ready, in_valid, out_ready,
    input  estado, selDtWr, SelRegWr, Wr, CmdULA, LdPC, SelJMP, SelDesv,
           LdOUTPUT, in_ack, io_err
  );

  modport slave (
    input  OP, ResultULA, mem_ready, in_valid, out_ready,
    output estado, selDtWr, SelRegWr, Wr, CmdULA, LdPC, SelJMP, SelDesv,
           LdOUTPUT, in_ack, io_err
  );
endinterface

// File: rtl/ctrl_multiciclo_branch_eval.sv
// rtl/ctrl_multiciclo_branch_eval.sv - combinational branch condition evaluator
//
// Purpose: decides whether a conditional branch is taken from the ALU result,
// treating ResultULA as two's complement of any width.
// Ports: op (opcode), ResultULA (DATA_W ALU result), taken (branch taken).

module ctrl_branch_eval
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] ResultULA,
  output logic              taken
);

  logic neg;
  logic zero;

  assign neg  = ResultULA[DATA_W-1];
  assign zero = (ResultULA == '0);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BLT:  taken = neg;
      OP_BGT:  taken = !neg && !zero;
      OP_BEQ:  taken = zero;
      OP_BNE:  taken = !zero;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_multiciclo.sv
// rtl/ctrl_multiciclo.sv - multi-cycle control unit of the nano processor
//
// Purpose: sequences FETCH, WAIT, DECODE, EXEC, IOWAIT and UPDATE with a
// memory-ready handshake, handshaked I/O with optional timeout and branch
// evaluation. Every output is a register; estado is the state register.
// Ports: clk, rst (async, active-high); bus (ctrl_multiciclo_if.slave):
// OP, ResultULA, mem_ready, in_valid, out_ready in; estado, selDtWr,
// SelRegWr, Wr, CmdULA, LdPC, SelJMP, SelDesv, LdOUTPUT, in_ack, io_err out.

module ctrl_multiciclo
  import ctrl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FETCH_WAIT = 1,
  parameter int IO_TIMEOUT = 0
) (
  input logic clk,
  input logic rst,
  ctrl_multiciclo_if.slave bus
);

  localparam logic [3:0] WAIT_MIN = 4'(FETCH_WAIT - 1);
  localparam logic [7:0] IO_LIMIT = 8'(IO_TIMEOUT - 1);

  state_t     state, state_next;
  logic [3:0] op_q;
  logic [3:0] op_sel;
  logic [3:0] wait_cnt;
  logic [7:0] io_cnt;
  logic       taken;
  logic       io_done;
  logic       io_timeout;

  // Next values of the registered outputs
  logic [1:0] sel_dt_n, sel_dt_q;
  logic [2:0] cmd_n, cmd_q;
  logic       sel_reg_n, sel_reg_q;
  logic       wr_n, wr_q;
  logic       ld_pc_n, ld_pc_q;
  logic       sel_jmp_n, sel_jmp_q;
  logic       sel_desv_n, sel_desv_q;
  logic       ld_out_n, ld_out_q;
  logic       in_ack_n, in_ack_q;
  logic       io_err_n, io_err_q;

  // Outputs are registered from the next state, so entering DECODE must
  // already decode the live opcode; afterwards only the latched copy is used.
  assign op_sel = (state == S_WAIT) ? bus.OP : op_q;

  assign io_done = ((op_q == OP_INPUT) && bus.in_valid) ||
                   ((op_q == OP_OUTPUT) && bus.out_ready);
  assign io_timeout = (IO_TIMEOUT != 0) && (io_cnt == IO_LIMIT);

  ctrl_branch_eval #(.DATA_W(DATA_W)) u_branch_eval (
    .op       (op_q),
    .ResultULA(bus.ResultULA),
    .taken    (taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    sel_dt_n   = DT_ALU;
    cmd_n      = ALU_TSTR1;
    sel_reg_n  = 1'b0;
    wr_n       = 1'b0;
    ld_pc_n    = 1'b0;
    sel_jmp_n  = 1'b0;
    sel_desv_n = 1'b0;
    ld_out_n   = 1'b0;
    in_ack_n   = 1'b0;
    io_err_n   = 1'b0;

    case (state)
      S_FETCH:  state_next = S_WAIT;
      S_WAIT:   state_next = (wait_cnt >= WAIT_MIN && bus.mem_ready) ? S_DECODE : S_WAIT;
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = is_io(op_q) ? S_IOWAIT : S_UPDATE;
      S_IOWAIT: state_next = (io_done || io_timeout) ? S_UPDATE : S_IOWAIT;
      S_UPDATE: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase

    // ALU command and write selects stay stable from DECODE through UPDATE
    if (state_next inside {S_DECODE, S_EXEC, S_IOWAIT, S_UPDATE}) begin
      cmd_n     = alu_cmd(op_sel);
      sel_dt_n  = dt_sel(op_sel);
      sel_reg_n = (op_sel == OP_LRG);
    end

    case (state_next)
      S_EXEC: wr_n = writes_in_exec(op_sel);
      S_UPDATE: begin
        ld_pc_n    = 1'b1;
        sel_jmp_n  = (op_sel == OP_JMP);
        sel_desv_n = (state == S_EXEC) && taken;
        if (state == S_IOWAIT) begin
          // completion beats a timeout landing in the same cycle
          if (io_done) begin
            wr_n     = (op_sel == OP_INPUT);
            in_ack_n = (op_sel == OP_INPUT);
            ld_out_n = (op_sel == OP_OUTPUT);
          end else begin
            io_err_n = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_NOP;
      wait_cnt <= '0;
      io_cnt   <= '0;
    end else begin
      if (state == S_WAIT && state_next == S_DECODE) begin
        op_q <= bus.OP;
      end
      if (state == S_FETCH) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT && wait_cnt != 4'hF) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (state != S_IOWAIT) begin
        io_cnt <= '0;
      end else if (io_cnt != 8'hFF) begin
        io_cnt <= io_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_dt_q   <= DT_ALU;
      cmd_q      <= ALU_TSTR1;
      sel_reg_q  <= 1'b0;
      wr_q       <= 1'b0;
      ld_pc_q    <= 1'b0;
      sel_jmp_q  <= 1'b0;
      sel_desv_q <= 1'b0;
      ld_out_q   <= 1'b0;
      in_ack_q   <= 1'b0;
      io_err_q   <= 1'b0;
    end else begin
      sel_dt_q   <= sel_dt_n;
      cmd_q      <= cmd_n;
      sel_reg_q  <= sel_reg_n;
      wr_q       <= wr_n;
      ld_pc_q    <= ld_pc_n;
      sel_jmp_q  <= sel_jmp_n;
      sel_desv_q <= sel_desv_n;
      ld_out_q   <= ld_out_n;
      in_ack_q   <= in_ack_n;
      io_err_q   <= io_err_n;
    end
  end

  assign bus.estado   = state;
  assign bus.selDtWr  = sel_dt_q;
  assign bus.SelRegWr = sel_reg_q;
  assign bus.Wr       = wr_q;
  assign bus.CmdULA   = cmd_q;
  assign bus.LdPC     = ld_pc_q;
  assign bus.SelJMP   = sel_jmp_q;
  assign bus.SelDesv  = sel_desv_q;
  assign bus.LdOUTPUT = ld_out_q;
  assign bus.in_ack   = in_ack_q;
  assign bus.io_err   = io_err_q;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// tb/tb_ctrl_multiciclo.sv - scoreboard testbench for ctrl_multiciclo
//
// Purpose: runs two controller instances (8-bit/FETCH_WAIT=1/no timeout and
// 16-bit/FETCH_WAIT=3/IO_TIMEOUT=4) and checks every cycle of each
// instruction against expected output vectors queued as stimulus is driven.
// Vector layout: estado[15:13] selDtWr[12:11] SelRegWr[10] Wr[9] CmdULA[8:6]
// LdPC[5] SelJMP[4] SelDesv[3] LdOUTPUT[2] in_ack[1] io_err[0].

module tb_ctrl_multiciclo;
  import ctrl_pkg::*;

  typedef struct {
    bit          b;
    logic [15:0] v;
    string       tag;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] res;
    logic        mr;
    logic        iv;
    logic        ordy;
    logic [15:0] nxt;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ctrl_multiciclo_if #(.DATA_W(8))  ifa ();
  ctrl_multiciclo_if #(.DATA_W(16)) ifb ();

  ctrl_multiciclo #(.DATA_W(8), .FETCH_WAIT(1), .IO_TIMEOUT(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  ctrl_multiciclo #(.DATA_W(16), .FETCH_WAIT(3), .IO_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  function automatic logic [15:0] obs(input bit b);
    if (b) return {ifb.estado, ifb.selDtWr, ifb.SelRegWr, ifb.Wr, ifb.CmdULA, ifb.LdPC,
                   ifb.SelJMP, ifb.SelDesv, ifb.LdOUTPUT, ifb.in_ack, ifb.io_err};
    return {ifa.estado, ifa.selDtWr, ifa.SelRegWr, ifa.Wr, ifa.CmdULA, ifa.LdPC,
            ifa.SelJMP, ifa.SelDesv, ifa.LdOUTPUT, ifa.in_ack, ifa.io_err};
  endfunction

  function automatic logic [15:0] vec(input logic [2:0] st, input logic [1:0] sd, input logic sr,
                                      input logic wr, input logic [2:0] cmd, input logic ldpc,
                                      input logic jmp, input logic desv, input logic ldout,
                                      input logic ack, input logic err);
    return {st, sd, sr, wr, cmd, ldpc, jmp, desv, ldout, ack, err};
  endfunction

  function automatic cyc_t mkc(input logic [3:0] op, input logic [15:0] res, input logic mr,
                               input logic iv, input logic ordy, input logic [15:0] nxt);
    cyc_t c;
    c.op = op; c.res = res; c.mr = mr; c.iv = iv; c.ordy = ordy; c.nxt = nxt;
    return c;
  endfunction

  function automatic logic [2:0] exp_cmd(input logic [3:0] op);
    case (op)
      OP_ADD:  return 3'd1;
      OP_AND:  return 3'd2;
      OP_OR:   return 3'd3;
      OP_SUB:  return 3'd4;
      OP_NEG:  return 3'd5;
      OP_NOT:  return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  task automatic drive(input cyc_t c);
    ifa.OP = c.op;          ifb.OP = c.op;
    ifa.ResultULA = c.res[7:0];
    ifb.ResultULA = c.res;
    ifa.mem_ready = c.mr;   ifb.mem_ready = c.mr;
    ifa.in_valid = c.iv;    ifb.in_valid = c.iv;
    ifa.out_ready = c.ordy; ifb.out_ready = c.ordy;
  endtask

  // Runs one instruction starting in its FETCH cycle. stall: cycles of
  // mem_ready low at the start of WAIT. hs: IOWAIT cycles before the
  // handshake (-1 = never). abort: stop once EXEC is expected next.
  task automatic run_instr(input bit b, input string tag, input logic [3:0] op,
                           input logic [15:0] res, input int stall, input int hs,
                           input bit exp_desv, input bit abort);
    int fw, tmo, nw, niow;
    bit io, done, hsact;
    logic [2:0] cmd;
    logic [1:0] sd;
    logic sr, wrx;
    logic [15:0] upd, iow;
    cyc_t plan[$];
    exp_t e;
    fw  = b ? 3 : 1;
    tmo = b ? 4 : 0;
    io  = (op == OP_INPUT) || (op == OP_OUTPUT);
    nw  = (stall + 1 > fw) ? stall + 1 : fw;
    if (hs >= 0 && (tmo == 0 || hs < tmo)) begin done = 1; niow = hs + 1; end
    else begin done = 0; niow = tmo; end
    cmd = exp_cmd(op);
    sd  = (op == OP_LRG) ? 2'd1 : (op == OP_INPUT) ? 2'd2 : 2'd0;
    sr  = (op == OP_LRG);
    wrx = (op == OP_ADD) || (op == OP_AND) || (op == OP_OR) || (op == OP_SUB) ||
          (op == OP_NEG) || (op == OP_NOT) || (op == OP_CPY) || (op == OP_LRG);
    upd = vec(3'd5, sd, sr, io && done && op == OP_INPUT, cmd, 1'b1, op == OP_JMP, exp_desv,
              io && done && op == OP_OUTPUT, io && done && op == OP_INPUT, io && !done);
    iow = vec(3'd4, sd, sr, 0, cmd, 0, 0, 0, 0, 0, 0);

    plan.push_back(mkc(op, ~res, stall == 0, 0, 0, vec(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    for (int i = 0; i < nw; i++)
      plan.push_back(mkc(op, ~res, i >= stall, 0, 0,
                         (i == nw - 1) ? vec(3'd2, sd, sr, 0, cmd, 0, 0, 0, 0, 0, 0)
                                       : vec(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    plan.push_back(mkc(op, ~res, 1, 0, 0, vec(3'd3, sd, sr, wrx, cmd, 0, 0, 0, 0, 0, 0)));
    if (!abort) begin
      plan.push_back(mkc(~op, res, 1, 0, 0, io ? iow : upd));
      if (io) begin
        for (int j = 0; j < niow; j++) begin
          hsact = (hs >= 0) && (j >= hs);
          plan.push_back(mkc(~op, ~res, 1, op == OP_INPUT && hsact, op == OP_OUTPUT && hsact,
                             (j == niow - 1) ? upd : iow));
        end
      end
      plan.push_back(mkc(~op, ~res, 1, 0, 0, 16'h0000));
    end

    foreach (plan[k]) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.b) !== e.v) begin
          errors++;
          $display("FAIL %s dut%0d got=%h required=%h (estado got %0d required %0d)",
                   e.tag, e.b, obs(e.b), e.v, obs(e.b) >> 13, e.v >> 13);
        end
      end
      drive(plan[k]);
      e.b = b; e.v = plan[k].nxt; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  // Leaves both instances in a visible FETCH cycle, just past a rising edge.
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.b) !== e.v) begin
        errors++;
        $display("FAIL %s dut%0d got=%h required=%h", e.tag, e.b, obs(e.b), e.v);
      end
    end
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d[0]) !== 16'h0000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got=%h required=0000", d, obs(d[0]));
      end
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d[0]) !== 16'h0000) begin
        errors++;
        $display("FAIL release_fetch dut%0d got=%h required=0000", d, obs(d[0]));
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_instr(0, "add",  OP_ADD,  16'h0011, 0, -1, 0, 0);
    run_instr(0, "and",  OP_AND,  16'h0022, 0, -1, 0, 0);
    run_instr(0, "or",   OP_OR,   16'h0000, 0, -1, 0, 0);
    run_instr(0, "sub",  OP_SUB,  16'h00FF, 0, -1, 0, 0);
    run_instr(0, "neg",  OP_NEG,  16'h0080, 0, -1, 0, 0);
    run_instr(0, "not",  OP_NOT,  16'h0001, 0, -1, 0, 0);
    run_instr(0, "cpy",  OP_CPY,  16'h0000, 0, -1, 0, 0);
    run_instr(0, "lrg",  OP_LRG,  16'h0000, 0, -1, 0, 0);
    run_instr(0, "jmp",  OP_JMP,  16'h0000, 0, -1, 0, 0);
    run_instr(0, "nop",  OP_NOP,  16'h0000, 0, -1, 0, 0);
  endtask

  task automatic test_branch();
    do_reset();
    run_instr(0, "bgt_00",   OP_BGT, 16'h0000, 0, -1, 0, 0);
    run_instr(0, "bgt_05",   OP_BGT, 16'h0005, 0, -1, 1, 0);
    run_instr(0, "bgt_80",   OP_BGT, 16'h0080, 0, -1, 0, 0);
    run_instr(0, "blt_80",   OP_BLT, 16'h0080, 0, -1, 1, 0);
    run_instr(0, "blt_7f",   OP_BLT, 16'h007F, 0, -1, 0, 0);
    run_instr(0, "beq_00",   OP_BEQ, 16'h0000, 0, -1, 1, 0);
    run_instr(0, "bne_00",   OP_BNE, 16'h0000, 0, -1, 0, 0);
    run_instr(0, "bne_03",   OP_BNE, 16'h0003, 0, -1, 1, 0);
    do_reset();
    run_instr(1, "blt_8000", OP_BLT, 16'h8000, 0, -1, 1, 0);
    run_instr(1, "blt_0080", OP_BLT, 16'h0080, 0, -1, 0, 0);
    run_instr(1, "bgt_0080", OP_BGT, 16'h0080, 0, -1, 1, 0);
  endtask

  task automatic test_input();
    do_reset();
    run_instr(0, "input_hs3",  OP_INPUT,  16'h0000, 0, 3, 0, 0);
    run_instr(0, "input_hs0",  OP_INPUT,  16'h0000, 0, 0, 0, 0);
    run_instr(0, "output_hs2", OP_OUTPUT, 16'h0000, 0, 2, 0, 0);
  endtask

  task automatic test_io_timeout();
    do_reset();
    run_instr(1, "output_timeout", OP_OUTPUT, 16'h0000, 0, -1, 0, 0);
    run_instr(1, "output_last",    OP_OUTPUT, 16'h0000, 0, 3, 0, 0);
    run_instr(1, "input_timeout",  OP_INPUT,  16'h0000, 0, -1, 0, 0);
    run_instr(1, "add_after_io",   OP_ADD,    16'h0000, 0, -1, 0, 0);
  endtask

  task automatic test_fetch_stall();
    do_reset();
    run_instr(1, "add_stall5", OP_ADD, 16'h0000, 5, -1, 0, 0);
    run_instr(1, "lrg_nostall", OP_LRG, 16'h0000, 0, -1, 0, 0);
    run_instr(1, "sub_stall1", OP_SUB, 16'h0000, 1, -1, 0, 0);
  endtask

  task automatic test_async_reset();
    exp_t e;
    bit saw_ldpc;
    do_reset();
    run_instr(0, "abort_add", OP_ADD, 16'h0000, 0, -1, 0, 1);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs(0) !== e.v) begin
      errors++;
      $display("FAIL abort_exec got=%h required=%h", obs(0), e.v);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ifa.Wr !== 1'b0) begin
      errors++;
      $display("FAIL abort_wr_drop got=%b required=0", ifa.Wr);
    end
    checks++;
    if (ifa.estado !== 3'd0) begin
      errors++;
      $display("FAIL abort_estado got=%0d required=0", ifa.estado);
    end
    saw_ldpc = ifa.LdPC;
    repeat (3) begin
      @(negedge clk);
      if (ifa.LdPC !== 1'b0) saw_ldpc = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (ifa.estado !== 3'd0) begin
      errors++;
      $display("FAIL abort_release_estado got=%0d required=0", ifa.estado);
    end
    @(negedge clk);
    if (ifa.LdPC !== 1'b0) saw_ldpc = 1'b1;
    checks++;
    if (saw_ldpc) begin
      errors++;
      $display("FAIL abort_no_ldpc got=1 required=0");
    end
    // earlier negedge consumed the FETCH cycle: line up on the next FETCH
    do_reset();
    run_instr(0, "post_abort_add", OP_ADD, 16'h0000, 0, -1, 0, 0);
  endtask

  initial begin
    drive(mkc(OP_NOP, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000));
    test_reset();
    test_back_to_back();
    test_branch();
    test_input();
    test_io_timeout();
    test_fetch_stall();
    test_async_reset();
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
